cop_irq_ctl: RTL and testbench

// - Responder on the core's coprocessor bus (cop_addr/cop_data/cop_mem_ctl -> cop_dout) and source of irq/irq_addr, consuming iack.
// - Holds an NSRC-input vectored interrupt controller plus one down-counting timer, wired as source 0.
// - Sits beside the core at top level; its cop_dout drives the core's OR'd read-return port.

---
 rtl/cop_irq_ctl_pkg.sv | 33 +++
 rtl/cop_timer.sv | 78 +++++++
 rtl/cop_irq_ctl.sv | 192 +++++++++++++++++++
 tb/tb_cop_irq_ctl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cop_irq_ctl_pkg.sv
// Shared definitions for the coprocessor interrupt controller slice.
// Bus command codes (dmem_ctl encoding), register word offsets and the
// request FSM state type.
package cop_irq_ctl_pkg;

    // dmem_ctl bus command codes
    localparam logic [3:0] DMEM_NOP = 4'd0;
    localparam logic [3:0] DMEM_LBS = 4'd1;
    localparam logic [3:0] DMEM_LB  = 4'd2;
    localparam logic [3:0] DMEM_LHS = 4'd3;
    localparam logic [3:0] DMEM_LH  = 4'd4;
    localparam logic [3:0] DMEM_LW  = 4'd5;
    localparam logic [3:0] DMEM_SB  = 4'd6;
    localparam logic [3:0] DMEM_SH  = 4'd7;
    localparam logic [3:0] DMEM_SW  = 4'd8;

    // Register word offsets (cop_addr[4:2])
    localparam logic [2:0] OFF_PEND  = 3'd0;
    localparam logic [2:0] OFF_MASK  = 3'd1;
    localparam logic [2:0] OFF_VBASE = 3'd2;
    localparam logic [2:0] OFF_CUR   = 3'd3;
    localparam logic [2:0] OFF_EOI   = 3'd4;
    localparam logic [2:0] OFF_TLOAD = 3'd5;
    localparam logic [2:0] OFF_TCNT  = 3'd6;
    localparam logic [2:0] OFF_TCTL  = 3'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StSvc  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/cop_timer.sv
// Down-counting timer for the interrupt controller.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   tload_we_i     write TLOAD (also loads TCNT) with wdata_i
//   tctl_we_i      write TCTL {reload, en} from wdata_i[1:0]
//   wdata_i        bus write data
//   tload_o        TLOAD register
//   tcnt_o         current count
//   tctl_o         {reload, en}
//   fire_o         high on the cycle TCNT goes 1 -> 0
module cop_timer
    import cop_irq_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tload_we_i,
    input  logic        tctl_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] tload_o,
    output logic [31:0] tcnt_o,
    output logic [1:0]  tctl_o,
    output logic        fire_o
);

    logic [31:0] tload_q, tload_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        en_q, en_d;
    logic        reload_q, reload_d;

    assign fire_o  = en_q && (tcnt_q == 32'd1);
    assign tload_o = tload_q;
    assign tcnt_o  = tcnt_q;
    assign tctl_o  = {reload_q, en_q};

    always_comb begin
        tload_d  = tload_q;
        tcnt_d   = tcnt_q;
        en_d     = en_q;
        reload_d = reload_q;
        // A zero count with en set stays idle and never fires.
        if (en_q && (tcnt_q != 32'd0)) begin
            if (fire_o) begin
                if (reload_q) begin
                    tcnt_d = tload_q;
                end else begin
                    tcnt_d = 32'd0;
                    en_d   = 1'b0;
                end
            end else begin
                tcnt_d = tcnt_q - 32'd1;
            end
        end
        // Bus writes override the counting update in the same cycle.
        if (tload_we_i) begin
            tload_d = wdata_i;
            tcnt_d  = wdata_i;
        end
        if (tctl_we_i) begin
            en_d     = wdata_i[0];
            reload_d = wdata_i[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tload_q  <= 32'd0;
            tcnt_q   <= 32'd0;
            en_q     <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            tload_q  <= tload_d;
            tcnt_q   <= tcnt_d;
            en_q     <= en_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/cop_irq_ctl.sv
// Vectored interrupt controller on the coprocessor bus with one timer as
// source 0 and NSRC-1 rising-edge external sources.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   pause           pipeline stall: bus ignored, cop_dout_o held
//   cop_addr_i      bus address; cop_data_i write data; cop_mem_ctl_i command
//   cop_dout_o      registered read data, 0 when not addressed
//   ext_irq_i       external interrupt sources 1..NSRC-1
//   irq_o           interrupt request; irq_addr_o its vector
//   iack_i          core acceptance pulse
module cop_irq_ctl
    import cop_irq_ctl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned NSRC      = 8,
    parameter logic [31:0] VEC_RESET = 32'h0000_0050,
    parameter int unsigned VEC_SHIFT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pause,
    input  logic [31:0]     cop_addr_i,
    input  logic [31:0]     cop_data_i,
    input  logic [3:0]      cop_mem_ctl_i,
    output logic [31:0]     cop_dout_o,
    input  logic [NSRC-2:0] ext_irq_i,
    output logic            irq_o,
    output logic [31:0]     irq_addr_o,
    input  logic            iack_i
);

    logic            hit, acc, rd_en, wr_en;
    logic [2:0]      off;
    logic            we_pend, we_mask, we_vbase, we_eoi, we_tload, we_tctl;
    logic            unused_addr;

    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] eligible, set_bits, w1c_bits, ack_clr, idx_oh;
    logic [NSRC-2:0] ext_q;
    logic [31:0]     vbase_q, vbase_d;
    irq_state_e      state_q, state_d;
    logic [4:0]      idx_q, idx_d, win_idx;
    logic            irq_q, irq_d;
    logic [31:0]     irq_addr_q, irq_addr_d;
    logic [31:0]     dout_q, dout_d, rdata, win_vec;

    logic [31:0]     tload, tcnt;
    logic [1:0]      tctl;
    logic            fire;

    // Bus decode
    assign unused_addr = ^cop_addr_i[1:0];
    assign hit   = (cop_addr_i[31:5] == BASE_ADDR[31:5]);
    assign off   = cop_addr_i[4:2];
    assign acc   = hit && !pause;
    assign rd_en = acc && (cop_mem_ctl_i == DMEM_LW);
    assign wr_en = acc && (cop_mem_ctl_i == DMEM_SW);

    assign we_pend  = wr_en && (off == OFF_PEND);
    assign we_mask  = wr_en && (off == OFF_MASK);
    assign we_vbase = wr_en && (off == OFF_VBASE);
    assign we_eoi   = wr_en && (off == OFF_EOI);
    assign we_tload = wr_en && (off == OFF_TLOAD);
    assign we_tctl  = wr_en && (off == OFF_TCTL);

    cop_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .tload_we_i (we_tload),
        .tctl_we_i  (we_tctl),
        .wdata_i    (cop_data_i),
        .tload_o    (tload),
        .tcnt_o     (tcnt),
        .tctl_o     (tctl),
        .fire_o     (fire)
    );

    // Sources: timer is bit 0, external rising edges above it.
    assign set_bits = {ext_irq_i & ~ext_q, fire};
    assign w1c_bits = we_pend ? cop_data_i[NSRC-1:0] : '0;
    assign eligible = pend_q & mask_q;
    assign idx_oh   = {{(NSRC-1){1'b0}}, 1'b1} << idx_q;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win_idx = 5'd0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 5'(i);
            end
        end
    end

    assign win_vec = vbase_q + ({27'd0, win_idx} << VEC_SHIFT);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        irq_d      = irq_q;
        irq_addr_d = irq_addr_q;
        ack_clr    = '0;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d    = StReq;
                    idx_d      = win_idx;
                    irq_d      = 1'b1;
                    irq_addr_d = win_vec;
                end
            end
            StReq: begin
                // iack outranks a same-cycle W1C or mask drop of the winner.
                if (iack_i) begin
                    state_d = StSvc;
                    irq_d   = 1'b0;
                    ack_clr = idx_oh;
                end else if (!(|(eligible & idx_oh))) begin
                    state_d = StIdle;
                    irq_d   = 1'b0;
                    idx_d   = 5'd0;
                end
            end
            StSvc: begin
                if (we_eoi) begin
                    state_d = StIdle;
                    idx_d   = 5'd0;
                end
            end
            default: begin
                state_d = StIdle;
                irq_d   = 1'b0;
                idx_d   = 5'd0;
            end
        endcase
    end

    // New edges win over any clear in the same cycle.
    assign pend_d  = (pend_q & ~w1c_bits & ~ack_clr) | set_bits;
    assign mask_d  = we_mask ? cop_data_i[NSRC-1:0] : mask_q;
    assign vbase_d = we_vbase ? cop_data_i : vbase_q;

    always_comb begin
        rdata = 32'd0;
        case (off)
            OFF_PEND:  rdata = 32'(pend_q);
            OFF_MASK:  rdata = 32'(mask_q);
            OFF_VBASE: rdata = vbase_q;
            OFF_CUR:   rdata = {(state_q == StSvc), 26'd0, idx_q};
            OFF_TLOAD: rdata = tload;
            OFF_TCNT:  rdata = tcnt;
            OFF_TCTL:  rdata = {30'd0, tctl};
            default:   rdata = 32'd0;
        endcase
    end

    always_comb begin
        dout_d = dout_q;
        if (!pause) begin
            dout_d = rd_en ? rdata : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q     <= '0;
            mask_q     <= '0;
            ext_q      <= '0;
            vbase_q    <= VEC_RESET;
            state_q    <= StIdle;
            idx_q      <= 5'd0;
            irq_q      <= 1'b0;
            irq_addr_q <= VEC_RESET;
            dout_q     <= 32'd0;
        end else begin
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            ext_q      <= ext_irq_i;
            vbase_q    <= vbase_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            irq_q      <= irq_d;
            irq_addr_q <= irq_addr_d;
            dout_q     <= dout_d;
        end
    end

    assign cop_dout_o = dout_q;
    assign irq_o      = irq_q;
    assign irq_addr_o = irq_addr_q;

endmodule

// File: tb/tb_cop_irq_ctl.sv
// Directed bench for cop_irq_ctl with a behavioural reference model checked
// every cycle plus literal expectations at key points.
module tb_cop_irq_ctl;
    import cop_irq_ctl_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam int NS = 8;

    logic        clk = 1'b0;
    logic        rst, pause, iack_i, irq_o;
    logic [31:0] cop_addr_i, cop_data_i, cop_dout_o, irq_addr_o;
    logic [3:0]  cop_mem_ctl_i;
    logic [6:0]  ext_irq_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cop_irq_ctl dut (
        .clk           (clk),
        .rst           (rst),
        .pause         (pause),
        .cop_addr_i    (cop_addr_i),
        .cop_data_i    (cop_data_i),
        .cop_mem_ctl_i (cop_mem_ctl_i),
        .cop_dout_o    (cop_dout_o),
        .ext_irq_i     (ext_irq_i),
        .irq_o         (irq_o),
        .irq_addr_o    (irq_addr_o),
        .iack_i        (iack_i)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sources as arrays, request state as two flags.
    bit          m_pend[NS];
    bit          m_mask[NS];
    bit          m_prev[NS-1];
    logic [31:0] m_vbase, m_tload, m_tcnt, m_dout, m_addr;
    bit          m_ten, m_trel, m_irq, m_offered, m_serving;
    int          m_who;

    function automatic logic [31:0] model_reg(int word);
        logic [31:0] v;
        v = 32'd0;
        case (word)
            0: for (int i = 0; i < NS; i++) v[i] = m_pend[i];
            1: for (int i = 0; i < NS; i++) v[i] = m_mask[i];
            2: v = m_vbase;
            3: begin
                v = (m_who < 0) ? 32'd0 : 32'(m_who);
                if (m_serving) v[31] = 1'b1;
            end
            5: v = m_tload;
            6: v = m_tcnt;
            7: v = {30'd0, m_trel, m_ten};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_step();
        bit          acc, rd, wr, fire;
        bit          nset[NS];
        int          word, win, clr;
        logic [31:0] d, ndout;
        if (!rst) begin
            for (int i = 0; i < NS; i++) begin m_pend[i] = 0; m_mask[i] = 0; end
            for (int i = 0; i < NS - 1; i++) m_prev[i] = 0;
            m_vbase = 32'h50; m_tload = 0; m_tcnt = 0; m_ten = 0; m_trel = 0;
            m_dout = 0; m_irq = 0; m_addr = 32'h50;
            m_offered = 0; m_serving = 0; m_who = -1;
            return;
        end
        acc  = (cop_addr_i[31:5] == BASE[31:5]) && !pause;
        word = int'(cop_addr_i[4:2]);
        rd   = acc && (cop_mem_ctl_i == DMEM_LW);
        wr   = acc && (cop_mem_ctl_i == DMEM_SW);
        d    = cop_data_i;
        ndout = pause ? m_dout : (rd ? model_reg(word) : 32'd0);
        fire = m_ten && (m_tcnt == 1);
        nset[0] = fire;
        for (int i = 1; i < NS; i++) nset[i] = ext_irq_i[i-1] && !m_prev[i-1];
        win = -1;
        for (int i = NS - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
        clr = -1;
        if (m_serving) begin
            if (wr && word == 4) begin m_serving = 0; m_who = -1; end
        end else if (m_offered) begin
            if (iack_i) begin
                clr = m_who; m_offered = 0; m_serving = 1; m_irq = 0;
            end else if (!(m_pend[m_who] && m_mask[m_who])) begin
                m_offered = 0; m_who = -1; m_irq = 0;
            end
        end else if (win >= 0) begin
            m_offered = 1; m_who = win; m_irq = 1;
            m_addr = m_vbase + 32'(win) * 32'd8;
        end
        if (wr && word == 5) begin
            m_tload = d; m_tcnt = d;
        end else if (m_ten && m_tcnt != 0) begin
            m_tcnt = fire ? (m_trel ? m_tload : 32'd0) : m_tcnt - 1;
        end
        if (wr && word == 7) begin
            m_ten = d[0]; m_trel = d[1];
        end else if (fire && !m_trel) begin
            m_ten = 0;
        end
        for (int i = 0; i < NS; i++) begin
            if (wr && word == 0 && d[i]) m_pend[i] = 0;
            if (i == clr) m_pend[i] = 0;
            if (nset[i]) m_pend[i] = 1;
            if (wr && word == 1) m_mask[i] = d[i];
        end
        if (wr && word == 2) m_vbase = d;
        for (int i = 0; i < NS - 1; i++) m_prev[i] = ext_irq_i[i];
        m_dout = ndout;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("model_irq", {31'd0, irq_o}, {31'd0, m_irq});
            check("model_irq_addr", irq_addr_o, m_addr);
            check("model_dout", cop_dout_o, m_dout);
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(logic [3:0] ctl, logic [31:0] addr, logic [31:0] data);
        cop_mem_ctl_i = ctl;
        cop_addr_i    = addr;
        cop_data_i    = data;
        @(negedge clk);
        cop_mem_ctl_i = DMEM_NOP;
        cop_addr_i    = 32'd0;
        cop_data_i    = 32'd0;
    endtask

    task automatic wr(logic [31:0] off, logic [31:0] data);
        bus(DMEM_SW, BASE + off, data);
    endtask

    task automatic rd(logic [31:0] off, logic [31:0] exp, string name);
        bus(DMEM_LW, BASE + off, 32'd0);
        check(name, cop_dout_o, exp);
    endtask

    task automatic ack();
        iack_i = 1'b1;
        @(negedge clk);
        iack_i = 1'b0;
    endtask

    logic [31:0] tcnt_exp [6] = '{32'd3, 32'd2, 32'd1, 32'd3, 32'd2, 32'd1};

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pause = 1'(($urandom));  iack_i = 1'($urandom);
            cop_addr_i = $urandom;   cop_data_i = $urandom;
            cop_mem_ctl_i = 4'($urandom); ext_irq_i = 7'($urandom);
            @(negedge clk);
        end
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_irq_addr", irq_addr_o, 32'h50);
        check("rst_dout", cop_dout_o, 32'd0);
        pause = 0; iack_i = 0; ext_irq_i = 0;
        cop_addr_i = 0; cop_data_i = 0; cop_mem_ctl_i = DMEM_NOP;
        rst = 1'b1;
        rd(32'h08, 32'h50, "vbase_rst");

        // Single external source 2
        wr(32'h04, 32'h04);
        ext_irq_i = 7'b0000010;
        tick(1);
        ext_irq_i = 0;
        check("irq_pre", {31'd0, irq_o}, 32'd0);
        tick(1);
        check("irq_ext", {31'd0, irq_o}, 32'd1);
        check("vec_ext", irq_addr_o, 32'h60);
        ack();
        check("irq_acked", {31'd0, irq_o}, 32'd0);
        rd(32'h00, 32'd0, "pend_ack");
        rd(32'h0C, 32'h8000_0002, "cur_svc");
        wr(32'h10, 32'd0);
        rd(32'h0C, 32'd0, "cur_eoi");

        // Priority and winner hold
        wr(32'h04, 32'h00);
        ext_irq_i = 7'b0010100;
        tick(1);
        ext_irq_i = 0;
        wr(32'h04, 32'hFF);
        tick(1);
        check("vec_idx3", irq_addr_o, 32'h68);
        ext_irq_i = 7'b0000001;
        tick(1);
        ext_irq_i = 0;
        tick(2);
        check("hold_idx3", irq_addr_o, 32'h68);
        rd(32'h0C, 32'h3, "cur_req");
        ack();
        wr(32'h10, 32'd0);
        tick(1);
        check("vec_idx1", irq_addr_o, 32'h58);
        ack();
        wr(32'h10, 32'd0);
        tick(1);
        check("vec_idx5", irq_addr_o, 32'h78);
        ack();
        wr(32'h10, 32'd0);

        // Timer periodic then one-shot
        wr(32'h04, 32'h00);
        wr(32'h14, 32'd3);
        wr(32'h1C, 32'd3);
        for (int k = 0; k < 6; k++) rd(32'h18, tcnt_exp[k], "tcnt_seq");
        rd(32'h00, 32'h1, "pend_timer");
        wr(32'h1C, 32'd1);
        tick(2);
        rd(32'h1C, 32'd0, "tctl_oneshot");
        rd(32'h18, 32'd0, "tcnt_stop");
        wr(32'h00, 32'h1);
        tick(4);
        rd(32'h00, 32'd0, "pend_quiet");

        // Bus: pause, unmapped, sub-word
        rd(32'h08, 32'h50, "vbase_pre");
        pause = 1'b1;
        bus(DMEM_SW, BASE + 32'h04, 32'hFF);
        check("dout_hold", cop_dout_o, 32'h50);
        pause = 1'b0;
        rd(32'h04, 32'd0, "mask_paused");
        rd(32'h08, 32'h50, "vbase_pre2");
        bus(DMEM_LW, 32'hFFFE_0004, 32'd0);
        check("unmapped", cop_dout_o, 32'd0);
        rd(32'h08, 32'h50, "vbase_pre3");
        rd(32'h10, 32'd0, "eoi_read");
        bus(DMEM_SB, BASE + 32'h04, 32'hFF);
        bus(DMEM_SH, BASE + 32'h04, 32'hFF);
        rd(32'h04, 32'd0, "mask_sbsh");

        // Edge vs W1C, mask drop during REQ
        ext_irq_i = 7'b0100000;
        wr(32'h00, 32'h40);
        ext_irq_i = 0;
        rd(32'h00, 32'h40, "race_w1c");
        wr(32'h04, 32'h40);
        tick(1);
        check("vec_idx6", irq_addr_o, 32'h80);
        wr(32'h04, 32'h00);
        tick(1);
        check("mask_drop", {31'd0, irq_o}, 32'd0);
        rd(32'h0C, 32'd0, "cur_drop");
        wr(32'h00, 32'hFF);

        // Vector wrap; iack wins over same-cycle W1C
        wr(32'h08, 32'hFFFF_FFF8);
        wr(32'h04, 32'h80);
        ext_irq_i = 7'b1000000;
        tick(1);
        ext_irq_i = 0;
        tick(1);
        check("vec_wrap", irq_addr_o, 32'h30);
        iack_i = 1'b1;
        wr(32'h00, 32'h80);
        iack_i = 1'b0;
        rd(32'h0C, 32'h8000_0007, "cur_iack_w1c");
        rd(32'h00, 32'd0, "pend_after");
        wr(32'h10, 32'd0);

        // Reset mid-service
        wr(32'h04, 32'h02);
        ext_irq_i = 7'b0000001;
        tick(1);
        ext_irq_i = 0;
        tick(1);
        check("vec_wrap0", irq_addr_o, 32'h0);
        ack();
        rd(32'h0C, 32'h8000_0001, "cur_svc1");
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        check("rst_mid_irq_addr", irq_addr_o, 32'h50);
        rd(32'h0C, 32'd0, "cur_rst");
        rd(32'h04, 32'd0, "mask_rst");
        rd(32'h08, 32'h50, "vbase_rst2");
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
